// File: rtl/tick_timer_sched.sv
// Shared-decrementer timeout scheduler: one TICK starts a sweep that visits one channel per clk,
// counting down armed channels and pulsing expire on terminal count.
module tick_timer_sched #(
    parameter int N = 4,
    parameter int W = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [N-1:0]  arm,
    input  logic [W-1:0]  load_val,
    input  logic [N-1:0]  cancel,
    output logic [N-1:0]  arm_ack,
    output logic [N-1:0]  active,
    output logic [N-1:0]  expire,
    output logic          busy,
    output logic          overrun,
    output logic          dbg_state,
    output logic [IW-1:0] dbg_idx
);

    // Handshake: arm[i] is a level request held until arm_ack[i] pulses for one clk; the
    // request is accepted in the clk it is sampled high and granted, cancel[i] masks it that clk.
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic          pending, pending_n;
    logic          overrun_n;
    logic [N-1:0]  req, gnt;
    logic [W-1:0]  cnt [N];

    assign req       = arm & ~cancel;
    assign busy      = (state == SWEEP);
    assign dbg_state = (state == SWEEP);
    assign dbg_idx   = idx;

    // Fixed priority: scanning downward lets the lowest requesting index win.
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pending_n = pending;
        // A tick arriving while one is already buffered is always lost.
        overrun_n = overrun | (tick & pending);
        case (state)
            IDLE: begin
                if (pending || tick) begin
                    state_n   = SWEEP;
                    idx_n     = '0;
                    pending_n = 1'b0;
                end
            end
            SWEEP: begin
                if (idx == IW'(N - 1)) begin
                    idx_n = '0;
                    if (pending) begin
                        pending_n = 1'b0;
                    end else begin
                        state_n   = IDLE;
                        pending_n = tick;
                    end
                end else begin
                    idx_n = idx + 1'b1;
                    if (tick) pending_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            pending <= pending_n;
            overrun <= overrun_n;
        end
    end

    // Cancel beats arm beats the sweep step, so requester actions never race a decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_ack <= '0;
            active  <= '0;
            expire  <= '0;
            for (int c = 0; c < N; c++) cnt[c] <= '0;
        end else begin
            arm_ack <= gnt;
            expire  <= '0;
            for (int c = 0; c < N; c++) begin
                if (cancel[c]) begin
                    cnt[c]    <= '0;
                    active[c] <= 1'b0;
                end else if (gnt[c]) begin
                    cnt[c]    <= load_val;
                    active[c] <= (load_val != '0);
                    expire[c] <= (load_val == '0);
                end else if (state == SWEEP && idx == IW'(c) && active[c]) begin
                    if (cnt[c] == W'(1)) begin
                        cnt[c]    <= '0;
                        active[c] <= 1'b0;
                        expire[c] <= 1'b1;
                    end else if (cnt[c] != '0) begin
                        cnt[c] <= cnt[c] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched (N=4, W=16) with hand-computed expectations.
module tb_tick_timer_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  arm = '0;
    logic [15:0] load_val = '0;
    logic [3:0]  cancel = '0;
    logic [3:0]  arm_ack, active, expire;
    logic        busy, overrun, dbg_state;
    logic [1:0]  dbg_idx;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_cnt [4];
    logic [3:0] exp_q [$];

    tick_timer_sched #(.N(4), .W(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .arm(arm), .load_val(load_val), .cancel(cancel),
        .arm_ack(arm_ack), .active(active), .expire(expire), .busy(busy), .overrun(overrun),
        .dbg_state(dbg_state), .dbg_idx(dbg_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst)
            for (int c = 0; c < 4; c++)
                if (expire[c]) exp_cnt[c]++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        arm = '0;
        cancel = '0;
        tick = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        step(1);
    endtask

    task automatic arm_one(input string tag, input logic [3:0] mask, input logic [15:0] v);
        arm = mask;
        load_val = v;
        step(1);
        check_eq(tag, {28'd0, arm_ack}, {28'd0, mask});
        arm = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        #7;
        check_eq("rst_active", {28'd0, active}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        do_reset();

        // 1: single channel, three ticks
        arm_one("t1_ack", 4'b0100, 16'd3);
        check_eq("t1_active", {28'd0, active}, 32'h4);
        step(100);
        tick_pulse();
        step(99);
        tick_pulse();
        step(99);
        check_eq("t1_still_active", {28'd0, active}, 32'h4);
        check_eq("t1_no_early_exp", exp_cnt[2], 0);
        tick_pulse();
        step(2);
        check_eq("t1_exp_t3", {28'd0, expire}, 32'h0);
        step(1);
        check_eq("t1_exp_t4", {28'd0, expire}, 32'h4);
        step(1);
        check_eq("t1_exp_once", exp_cnt[2], 1);
        check_eq("t1_inactive", {28'd0, active}, 32'h0);

        // 2: simultaneous arms, priority order
        do_reset();
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        arm = 4'b1011;
        load_val = 16'd5;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_eq("t2_ack_order", {28'd0, arm_ack}, {28'd0, exp_q.pop_front()});
            arm = arm & ~arm_ack;
        end
        check_eq("t2_active", {28'd0, active}, 32'hb);

        // 3: cancel mid-count, cancel+arm collision
        do_reset();
        arm_one("t3_ack", 4'b0010, 16'd2);
        tick_pulse();
        step(2);
        check_eq("t3_active_mid", {28'd0, active}, 32'h2);
        cancel = 4'b0010;
        step(1);
        cancel = '0;
        check_eq("t3_cancelled", {28'd0, active}, 32'h0);
        tick_pulse();
        step(8);
        check_eq("t3_no_exp", exp_cnt[1], 0);
        arm = 4'b0110;
        cancel = 4'b0010;
        load_val = 16'd4;
        step(1);
        check_eq("t3_cancel_wins", {28'd0, arm_ack}, 32'h4);
        cancel = '0;
        arm = 4'b0010;
        step(1);
        check_eq("t3_retry_ack", {28'd0, arm_ack}, 32'h2);
        arm = '0;
        check_eq("t3_active_after", {28'd0, active}, 32'h6);

        // 4: buffered tick and overrun
        do_reset();
        tick_pulse();
        step(1);
        tick_pulse();
        step(1);
        check_eq("t4_busy_t4", {31'd0, busy}, 32'd1);
        check_eq("t4_idx_t4", {30'd0, dbg_idx}, 32'd3);
        step(1);
        check_eq("t4_back2back", {30'd0, busy, dbg_idx[0]}, 32'h2);
        step(3);
        check_eq("t4_busy_t8", {31'd0, busy}, 32'd1);
        step(1);
        check_eq("t4_idle_t9", {31'd0, busy}, 32'd0);
        check_eq("t4_no_overrun", {31'd0, overrun}, 32'd0);
        tick = 1'b1;
        step(3);
        tick = 1'b0;
        check_eq("t4_overrun", {31'd0, overrun}, 32'd1);
        step(20);
        check_eq("t4_overrun_sticky", {31'd0, overrun}, 32'd1);

        // 5: zero load, re-arm mid-count
        do_reset();
        arm = 4'b0001;
        load_val = 16'd0;
        step(1);
        check_eq("t5_zero_ack", {28'd0, arm_ack}, 32'h1);
        check_eq("t5_zero_exp", {28'd0, expire}, 32'h1);
        check_eq("t5_zero_inactive", {28'd0, active}, 32'h0);
        arm = '0;
        step(1);
        check_eq("t5_exp_pulse", {28'd0, expire | active}, 32'h0);
        arm_one("t5_ack_a", 4'b1000, 16'd5);
        tick_pulse();
        step(8);
        arm_one("t5_ack_b", 4'b1000, 16'd2);
        tick_pulse();
        step(8);
        check_eq("t5_rearm_mid", {31'd0, active[3]}, 32'd1);
        check_eq("t5_no_exp_yet", exp_cnt[3], 0);
        tick_pulse();
        step(8);
        check_eq("t5_rearm_exp", exp_cnt[3], 1);
        check_eq("t5_rearm_done", {28'd0, active}, 32'h0);

        // 6: async reset mid-sweep
        do_reset();
        arm_one("t6_ack", 4'b0001, 16'd3);
        tick_pulse();
        step(2);
        check_eq("t6_idx2", {30'd0, dbg_idx}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_out", {18'd0, arm_ack, active, expire, busy, overrun},
                 32'h0);
        #2 rst = 1'b0;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        step(1);
        arm_one("t6_ack2", 4'b0010, 16'd1);
        tick_pulse();
        step(1);
        check_eq("t6_exp_early", {28'd0, expire}, 32'h0);
        step(1);
        check_eq("t6_exp", {28'd0, expire}, 32'h2);
        step(1);
        check_eq("t6_ch0_quiet", exp_cnt[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
